// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-fetch responder and its decode-side consumers.
package imem_pkg;

    localparam int unsigned XLEN = 32;

    // Instruction emitted whenever decode must see a bubble.
    localparam logic [XLEN-1:0] DEFAULT_NOP_WORD = 32'h0000_0000;

    // Decode-side instruction bus.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic            valid;
    } instr_bus_t;

    // A fetch address is bad when it is not word aligned or lies beyond the RAM.
    function automatic logic addr_fault(input logic [XLEN-1:0] addr, input int unsigned aw);
        logic misaligned;
        logic out_of_range;
        misaligned   = (addr[1:0] != 2'b00);
        out_of_range = ((addr >> (aw + 2)) != '0);
        return misaligned | out_of_range;
    endfunction

endpackage

// File: rtl/imem_ram.sv
// DEPTH x DW instruction RAM: one write port, synchronous read-first read port.
module imem_ram #(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned AW    = 10,
    parameter int unsigned DW    = 32
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rdata_q;

    // Write lands unconditionally; a same-cycle read of that word returns the old contents.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: one-cycle fetch with stall, flush, fault reporting and boot load.
module imem_responder
    import imem_pkg::*;
#(
    parameter int unsigned     DEPTH    = 1024,
    parameter int unsigned     AW       = 10,
    parameter logic [XLEN-1:0] NOP_WORD = DEFAULT_NOP_WORD
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] i_addr_i,
    input  logic            i_fetch_en_i,
    input  logic            stall_i,
    input  logic            flush_i,
    input  logic            load_we_i,
    input  logic [AW-1:0]   load_addr_i,
    input  logic [XLEN-1:0] load_data_i,
    output logic [XLEN-1:0] instr_o,
    output logic [XLEN-1:0] instr_pc_o,
    output logic            instr_valid_o,
    output logic            fault_o,
    output logic [XLEN-1:0] fault_addr_o,
    output logic [XLEN-1:0] fetch_cnt_o
);

    localparam logic [XLEN-1:0] CNT_MAX = '1;

    logic [AW-1:0]   word_idx;
    logic            bad_addr;
    logic            deliver;
    logic [XLEN-1:0] ram_rdata;

    logic [XLEN-1:0] pc_q,         pc_d;
    logic            valid_q,      valid_d;
    logic            fault_q,      fault_d;
    logic [XLEN-1:0] fault_addr_q, fault_addr_d;
    logic [XLEN-1:0] cnt_q,        cnt_d;

    instr_bus_t      bus;

    assign word_idx = i_addr_i[AW+1:2];
    assign bad_addr = addr_fault(i_addr_i, AW);

    // A real instruction is delivered only when nothing higher-priority intervenes.
    assign deliver  = !flush_i && !stall_i && i_fetch_en_i && !bad_addr;

    // The RAM read register only advances on a delivering fetch, so it naturally holds through stalls.
    imem_ram #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (XLEN)
    ) u_ram (
        .clk     (clk),
        .we_i    (load_we_i),
        .waddr_i (load_addr_i),
        .wdata_i (load_data_i),
        .re_i    (deliver),
        .raddr_i (word_idx),
        .rdata_o (ram_rdata)
    );

    // Next-state for the output pipeline: flush, stall, bubble, fault, fetch in priority order.
    always_comb begin
        pc_d         = pc_q;
        valid_d      = valid_q;
        fault_d      = 1'b0;
        fault_addr_d = fault_addr_q;
        cnt_d        = cnt_q;

        if (flush_i) begin
            valid_d = 1'b0;
            pc_d    = i_addr_i;
        end else if (stall_i) begin
            valid_d = valid_q;
        end else if (!i_fetch_en_i) begin
            valid_d = 1'b0;
            pc_d    = i_addr_i;
        end else if (bad_addr) begin
            valid_d      = 1'b0;
            pc_d         = i_addr_i;
            fault_d      = 1'b1;
            fault_addr_d = i_addr_i;
        end else begin
            valid_d = 1'b1;
            pc_d    = i_addr_i;
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + XLEN'(1);
            end
        end
    end

    // Output pipeline registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q         <= '0;
            valid_q      <= 1'b0;
            fault_q      <= 1'b0;
            fault_addr_q <= '0;
            cnt_q        <= '0;
        end else begin
            pc_q         <= pc_d;
            valid_q      <= valid_d;
            fault_q      <= fault_d;
            fault_addr_q <= fault_addr_d;
            cnt_q        <= cnt_d;
        end
    end

    // Instruction is the RAM read register when valid, otherwise the NOP word.
    always_comb begin
        bus.pc    = pc_q;
        bus.valid = valid_q;
        bus.instr = valid_q ? ram_rdata : NOP_WORD;
    end

    assign instr_o       = bus.instr;
    assign instr_pc_o    = bus.pc;
    assign instr_valid_o = bus.valid;
    assign fault_o       = fault_q;
    assign fault_addr_o  = fault_addr_q;
    assign fetch_cnt_o   = cnt_q;

endmodule

// File: doc/imem_responder.md
Name: imem_responder

Overview:
- Instruction-memory responder at the far end of the PC fetch interface.
- Each cycle it accepts a fetch address and enable from the PC stage and reads an on-chip word-addressed instruction RAM.
- It returns the instruction, its PC and a valid flag to decode, one cycle later.
- It honours pipeline stall and flush, flags bad addresses, and provides a boot-time load port for filling the RAM.

Parameters:
- DEPTH, 1024, number of 32-bit instruction words (power of 2).
- AW, 10, word-address width = log2(DEPTH).
- NOP_WORD, 32'h0000_0000, instruction emitted on bubble, flush or fault.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset, asynchronous, active-low
- i_addr_i  input  32  byte fetch address from PC stage
- i_fetch_en_i  input  1  fetch request valid
- stall_i  input  1  hold current decode-side outputs
- flush_i  input  1  discard in-flight fetch (branch taken)
- load_we_i  input  1  boot loader write strobe
- load_addr_i  input  AW  loader word address
- load_data_i  input  32  loader write data
- instr_o  output  32  fetched instruction
- instr_pc_o  output  32  byte address of instr_o
- instr_valid_o  output  1  instr_o is a real instruction for decode
- fault_o  output  1  one-cycle pulse: the last fetch was misaligned or out of range
- fault_addr_o  output  32  address of the most recent fault, held until the next fault
- fetch_cnt_o  output  32  count of valid instructions delivered, saturating

Behaviour:
- Reset values:
  - instr_o = NOP_WORD; instr_pc_o = 0; instr_valid_o = 0.
  - fault_o = 0; fault_addr_o = 0; fetch_cnt_o = 0.
  - RAM contents are not reset.
- Latency: an address presented in cycle N with i_fetch_en_i=1 appears on instr_o/instr_pc_o/instr_valid_o in cycle N+1. Throughput is one word per cycle.
- Address decode:
  - word index = i_addr_i[AW+1:2].
  - Misaligned when i_addr_i[1:0] != 0.
  - Out of range when i_addr_i[31:AW+2] != 0.
  - Either condition is a fault.
- Output register update priority, evaluated at each rising edge:
  1. flush_i=1: instr_o=NOP_WORD, instr_valid_o=0, instr_pc_o=i_addr_i, fault_o=0. Flush beats stall.
  2. stall_i=1: all outputs hold; fault_o forced 0 (no repeated pulse); RAM read result discarded.
  3. i_fetch_en_i=0: bubble (NOP_WORD, valid=0); instr_pc_o=i_addr_i.
  4. Fault: instr_o=NOP_WORD, valid=0, fault_o=1, fault_addr_o=i_addr_i.
  5. Otherwise: instr_o=RAM[word index], instr_pc_o=i_addr_i, valid=1.
- Stall exit: the first cycle after stall_i falls delivers the instruction for the address presented in that cycle. The PC stage re-presents the held address during stall, so no word is lost.
- RAM read is synchronous and read-first. A load write and a fetch of the same word in the same cycle return the old data. The write lands regardless of stall or flush.
- fetch_cnt_o increments by 1 on each edge where instr_valid_o is being set to 1. It saturates at 32'hFFFF_FFFF and does not wrap.
- Reset asserted mid-operation: all outputs return immediately (asynchronously) to their reset values. The RAM is untouched, so a loaded program survives reset.
- i_fetch_en_i is low during boot load; loader writes proceed freely during that time.

Decomposition:
- Shared package imem_pkg:
  - XLEN=32.
  - Default NOP_WORD constant.
  - Address-fault decode function (misaligned / out-of-range).
  - Instruction-bus struct or typedef {pc, instr, valid} reused by decode.
- One sub-module imem_ram:
  - Single-port-write, synchronous-read-first RAM, DEPTH x 32.
  - Isolates the memory for later technology-macro substitution.
- The top level holds the output pipeline register, fault logic and counter.

Test Plan:
- Boot load then fetch: load words 0..3 = 11,22,33,44, enable fetch at addr 0,4,8,C -> instr_o 11,22,33,44 on cycles N+1..N+4, valid=1, instr_pc_o 0,4,8,C, fetch_cnt_o=4.
- Stall hold: fetch addr 4, assert stall_i 3 cycles with addr re-presented as 4 -> instr_o stays 22 and instr_pc_o stays 4 for all 3 cycles; fetch_cnt_o does not advance; resume at 8 -> 33.
- Flush vs stall: stall_i=1 and flush_i=1 in the same cycle at addr 8 -> next cycle instr_valid_o=0, instr_o=NOP_WORD; fault_o=0.
- Faults: fetch addr 32'h6 -> fault_o=1 for one cycle, fault_addr_o=6, valid=0. Fetch addr 32'h1000 with DEPTH=1024 -> fault_o=1, fault_addr_o=32'h1000, and 6 is replaced.
- Read-first collision: load_we_i to word 2 with data 99 while fetching addr 8 -> instr_o=33. Re-fetch addr 8 -> 99.
- Async reset mid-stream: drop rst_n between clock edges while valid=1 -> outputs reset immediately. After release, re-fetch addr 0 -> 11 (RAM preserved), fetch_cnt_o restarts at 1.
